// File: rtl/preset_sequencer.sv
// Steps a preset/terminal-pulse counter through a small table of reload values,
// repeating each entry a programmable number of times, with optional looping.
module preset_sequencer #(
  parameter int          DEPTH          = 4,
  parameter logic [7:0]  PRESET_DEFAULT = 8'd250,
  localparam int         AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [AW-1:0] last_idx,
  input  logic [7:0]    reps,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_data,
  input  logic          tpulse,
  output logic          preset,
  output logic [7:0]    preset_input,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] idx,
  output logic [15:0]   tick_total
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state, state_n;
  logic [7:0]    rep;
  logic [7:0]    reps_q;
  logic [AW-1:0] last_q;
  logic [7:0]    tbl [DEPTH];
  logic [7:0]    reps_m1;
  logic          last_rep;
  logic          last_ent;
  logic [AW-1:0] idx_nxt;

  // reps of 0 behaves as 1, so the final-rep compare is against max(reps-1, 0)
  assign reps_m1  = (reps_q == 8'd0) ? 8'd0 : reps_q - 8'd1;
  assign last_rep = (rep == reps_m1);
  assign last_ent = (idx >= last_q);
  assign idx_nxt  = idx + AW'(1);

  always_comb begin
    state_n = state;
    if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_n = LOAD;
        LOAD:    state_n = WAIT;
        WAIT:    if (tpulse) state_n = (last_rep && last_ent) ? DONE : LOAD;
        DONE:    state_n = loop_en ? LOAD : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      preset       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      preset_input <= 8'd0;
      idx          <= '0;
      rep          <= 8'd0;
      reps_q       <= 8'd0;
      last_q       <= '0;
      tick_total   <= 16'd0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= PRESET_DEFAULT;
    end else begin
      state  <= state_n;
      preset <= (state_n == LOAD);
      busy   <= (state_n != IDLE);
      done   <= (state_n == DONE);
      // Table reads below see the pre-write value on a colliding edge.
      if (cfg_we) tbl[cfg_addr] <= cfg_data;
      if (!stop) begin
        case (state)
          IDLE: if (start) begin
            idx          <= '0;
            rep          <= 8'd0;
            tick_total   <= 16'd0;
            last_q       <= last_idx;
            reps_q       <= reps;
            preset_input <= tbl[0];
          end
          WAIT: if (tpulse) begin
            tick_total <= tick_total + 16'd1;
            if (!last_rep) begin
              rep          <= rep + 8'd1;
              preset_input <= tbl[idx];
            end else if (!last_ent) begin
              idx          <= idx_nxt;
              rep          <= 8'd0;
              preset_input <= tbl[idx_nxt];
            end
          end
          DONE: if (loop_en) begin
            idx          <= '0;
            rep          <= 8'd0;
            preset_input <= tbl[0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_preset_sequencer.sv
// Self-checking bench: preset values are scoreboarded; timing/status checked inline per scenario.
module tb_preset_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, stop, loop_en, cfg_we, tpulse;
  logic [1:0] last_idx, cfg_addr;
  logic [7:0] reps, cfg_data;
  logic       preset, busy, done;
  logic [7:0] preset_input;
  logic [1:0] idx;
  logic [15:0] tick_total;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  preset_sequencer #(.DEPTH(4), .PRESET_DEFAULT(8'd250)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .last_idx(last_idx), .reps(reps), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .tpulse(tpulse), .preset(preset), .preset_input(preset_input),
    .busy(busy), .done(done), .idx(idx), .tick_total(tick_total)
  );

  always #5 clk = ~clk;

  // Scoreboard: every preset pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (preset === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_preset: got value %0d, required no preset", preset_input);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (preset_input !== e) begin
          errors++;
          $display("FAIL sb_preset_value: got %0d, required %0d", preset_input, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tp();
    tpulse = 1'b1; step(); tpulse = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d; step(); cfg_we = 1'b0;
  endtask

  task automatic go(input logic [1:0] li, input logic [7:0] r, input logic [7:0] first);
    last_idx = li; reps = r; start = 1'b1; exp_q.push_back(first);
    step(); start = 1'b0;
  endtask

  task automatic chk_preset(input string nm, input logic e);
    checks++;
    if (preset !== e) begin errors++; $display("FAIL %s: preset got %b, required %b", nm, preset, e); end
  endtask

  task automatic chk_done(input string nm, input logic e);
    checks++;
    if (done !== e) begin errors++; $display("FAIL %s: done got %b, required %b", nm, done, e); end
  endtask

  task automatic chk_busy(input string nm, input logic e);
    checks++;
    if (busy !== e) begin errors++; $display("FAIL %s: busy got %b, required %b", nm, busy, e); end
  endtask

  task automatic chk_tick(input string nm, input logic [15:0] e);
    checks++;
    if (tick_total !== e) begin errors++; $display("FAIL %s: tick_total got %0d, required %0d", nm, tick_total, e); end
  endtask

  task automatic test_reset();
    checks++;
    if ({preset, busy, done, idx, preset_input, tick_total} !== 29'd0) begin
      errors++;
      $display("FAIL reset_values: got p=%b b=%b d=%b i=%0d v=%0d t=%0d, required all 0",
               preset, busy, done, idx, preset_input, tick_total);
    end
  endtask

  task automatic test_reset_mid_wait();
    go(2'd1, 8'd1, 8'd250);
    chk_preset("start_latency", 1'b1);
    step();                               // WAIT
    exp_q.push_back(8'd250);
    tp();                                 // entry 1 load
    chk_tick("tick_before_reset", 16'd1);
    step();                               // WAIT on entry 1
    reset = 1'b1; #1;
    checks++;
    if ({preset, busy, idx, tick_total} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset: got p=%b b=%b i=%0d t=%0d, required all 0", preset, busy, idx, tick_total);
    end
    step(); reset = 1'b0; step();
    go(2'd0, 8'd1, 8'd250);               // table back at default
    step(); tp();
    chk_done("reset_default_done", 1'b1);
    step();
  endtask

  task automatic test_basic();
    wr(2'd0, 8'd10); wr(2'd1, 8'd20); wr(2'd2, 8'd30); wr(2'd3, 8'd40);
    go(2'd3, 8'd1, 8'd10);
    chk_preset("basic_start_lat", 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_preset("basic_wait_low", 1'b0);
      exp_q.push_back(8'(10 * (i + 1)));
      tp();
      chk_preset("basic_tp_lat", 1'b1);
    end
    step(); tp();
    chk_done("basic_done", 1'b1);
    chk_tick("basic_tick", 16'd4);
    chk_preset("basic_no_preset", 1'b0);
    step();
    chk_busy("basic_busy_after", 1'b0);
    chk_done("basic_done_pulse", 1'b0);
  endtask

  task automatic test_reps();
    wr(2'd0, 8'd5);
    go(2'd0, 8'd3, 8'd5);
    step(); exp_q.push_back(8'd5); tp();
    chk_done("reps_not_done1", 1'b0);
    step(); exp_q.push_back(8'd5); tp();
    step(); tp();
    chk_done("reps3_done", 1'b1);
    chk_tick("reps3_tick", 16'd3);
    step();
    go(2'd0, 8'd0, 8'd5);
    step(); tp();
    chk_done("reps0_done", 1'b1);
    chk_preset("reps0_single", 1'b0);
    step();
  endtask

  task automatic test_stop();
    go(2'd0, 8'd2, 8'd5);
    step(); exp_q.push_back(8'd5); tp();
    step();
    stop = 1'b1; tpulse = 1'b1; step(); stop = 1'b0; tpulse = 1'b0;
    chk_busy("stop_busy", 1'b0);
    chk_preset("stop_preset", 1'b0);
    chk_done("stop_done", 1'b0);
    chk_tick("stop_tick_hold", 16'd1);
    tp(); step();
    chk_tick("idle_tp_ignored", 16'd1);
    chk_busy("idle_tp_busy", 1'b0);
  endtask

  task automatic test_loop();
    wr(2'd0, 8'd7); wr(2'd1, 8'd9);
    loop_en = 1'b1;
    go(2'd1, 8'd1, 8'd7);
    step(); exp_q.push_back(8'd9); tp();
    step(); tp();
    chk_done("loop_done", 1'b1);
    exp_q.push_back(8'd7);
    step();
    chk_preset("loop_reload_lat", 1'b1);
    chk_tick("loop_tick_kept", 16'd2);
    checks++;
    if (idx !== 2'd0) begin errors++; $display("FAIL loop_idx: got %0d, required 0", idx); end
    step(); exp_q.push_back(8'd9); tp();
    chk_tick("loop_tick_cont", 16'd3);
    stop = 1'b1; step(); stop = 1'b0; loop_en = 1'b0;
  endtask

  task automatic test_cfg_collision();
    wr(2'd0, 8'd11); wr(2'd1, 8'd22);
    go(2'd1, 8'd2, 8'd11);
    step(); exp_q.push_back(8'd11); tp();
    step();
    exp_q.push_back(8'd22);               // old value on the colliding edge
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd99;
    tp(); cfg_we = 1'b0;
    step(); exp_q.push_back(8'd99); tp();
    step(); tp();
    chk_done("cfg_done", 1'b1);
    step();
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; loop_en = 0; cfg_we = 0; tpulse = 0;
    last_idx = 0; cfg_addr = 0; reps = 0; cfg_data = 0;
    #12;
    test_reset();
    step(); reset = 1'b0; step();
    test_reset_mid_wait();
    test_basic();
    test_reps();
    test_stop();
    test_loop();
    test_cfg_collision();
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending presets, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
